// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the ring token arbiter.
// Holds the FSM state encoding and a one-hot to index conversion.
package ring_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Widest requester vector the index helper accepts.
  localparam int MAX_N = 64;

  function automatic logic [31:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [31:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set req at or above the token bit, wrapping.
// Zero latency; no backpressure, pure function of req and token.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] token,
  output logic [N-1:0] winner,
  output logic         any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] sel;

  // Subtracting the token borrows up to the first set bit at/above it; the
  // upper copy of req supplies the wrapped-around candidates.
  assign dbl    = {req, req};
  assign sel    = dbl & ~(dbl - {{N{1'b0}}, token});
  assign winner = sel[N-1:0] | sel[2*N-1:N];
  assign any    = |req;

endmodule

// File: rtl/ring_token_arbiter.sv
// Round-robin token-ring arbiter with registered, held grants and a hold quota.
// Grant appears one edge after req; every release costs one idle turnaround cycle.
module ring_token_arbiter
  import ring_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int HW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_id,
  output logic [N-1:0]  token,
  output logic          expired
);

  state_t          state, state_d;
  logic [HW-1:0]   hold_cnt, hold_d;
  logic [N-1:0]    gnt_d, token_d;
  logic [IW-1:0]   gnt_id_d;
  logic            gnt_valid_d, expired_d;
  logic [N-1:0]    pick;
  logic            pick_any;
  logic            req_gone, quota_hit, hold_room;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .token  (token),
    .winner (pick),
    .any    (pick_any)
  );

  assign req_gone  = ~|(req & gnt);
  assign quota_hit = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
  // With no quota the counter just sticks at its top value.
  assign hold_room = (MAX_HOLD != 0) ? (hold_cnt < HW'(MAX_HOLD)) : (hold_cnt != '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      token     <= N'(1) << (N - 1);
      hold_cnt  <= '0;
      expired   <= 1'b0;
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      gnt_valid <= gnt_valid_d;
      gnt_id    <= gnt_id_d;
      token     <= token_d;
      hold_cnt  <= hold_d;
      expired   <= expired_d;
    end
  end

  always_comb begin
    state_d     = state;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    gnt_id_d    = gnt_id;
    token_d     = token;
    hold_d      = hold_cnt;
    expired_d   = 1'b0;
    unique case (state)
      IDLE: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        hold_d      = '0;
        if (pick_any) begin
          gnt_d       = pick;
          gnt_valid_d = 1'b1;
          gnt_id_d    = IW'(onehot_to_idx(MAX_N'(pick)));
          hold_d      = HW'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (req_gone || quota_hit) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          hold_d      = '0;
          // Token moves to the requester just past the winner.
          token_d     = {gnt[N-2:0], gnt[N-1]};
          expired_d   = quota_hit && !req_gone;
          state_d     = IDLE;
        end else if (hold_room) begin
          hold_d = hold_cnt + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Bench for ring_token_arbiter: directed literal scenarios plus randomized traffic
// checked every cycle against an index-level model, on MAX_HOLD=8 and MAX_HOLD=2 instances.
module tb_ring_token_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, req2;
  logic [3:0] gnt, gnt2, token, token2;
  logic       gnt_valid, gnt_valid2, expired, expired2;
  logic [1:0] gnt_id, gnt_id2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ring_token_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .token(token), .expired(expired)
  );

  ring_token_arbiter #(.N(4), .MAX_HOLD(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .gnt(gnt2), .gnt_valid(gnt_valid2),
    .gnt_id(gnt_id2), .token(token2), .expired(expired2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: owner index (-1 idle), token index, cycles held, expired flag.
  int owner[2];
  int tok[2];
  int held[2];
  int exp_m[2];
  int quota[2] = '{8, 2};
  bit model_ok = 1'b0;

  task automatic model_step(input int d, input logic [3:0] r);
    if (owner[d] < 0) begin
      exp_m[d] = 0;
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (tok[d] + i) % 4;
        if (r[c]) begin
          owner[d] = c;
          held[d]  = 1;
          break;
        end
      end
    end else if (!r[owner[d]] || (quota[d] != 0 && held[d] == quota[d])) begin
      exp_m[d] = r[owner[d]] ? 1 : 0;
      tok[d]   = (owner[d] + 1) % 4;
      owner[d] = -1;
      held[d]  = 0;
    end else begin
      exp_m[d] = 0;
      held[d]++;
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 2; d++) begin
        owner[d] = -1; tok[d] = 3; held[d] = 0; exp_m[d] = 0;
      end
      model_ok = 1'b1;
    end else if (model_ok) begin
      model_step(0, req);
      model_step(1, req2);
    end
  end

  logic [3:0] prev_g[2];

  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      logic [3:0] g[2], t[2];
      logic       v[2], e[2];
      logic [1:0] id[2];
      g[0] = gnt;  t[0] = token;  v[0] = gnt_valid;  e[0] = expired;  id[0] = gnt_id;
      g[1] = gnt2; t[1] = token2; v[1] = gnt_valid2; e[1] = expired2; id[1] = gnt_id2;
      for (int d = 0; d < 2; d++) begin
        logic [3:0] eg;
        eg = (owner[d] < 0) ? 4'b0000 : 4'(1 << owner[d]);
        check($sformatf("model gnt[%0d]", d), 32'(g[d]), 32'(eg));
        check($sformatf("model gnt_valid[%0d]", d), 32'(v[d]), (owner[d] >= 0) ? 1 : 0);
        check($sformatf("model gnt_id[%0d]", d), 32'(id[d]), (owner[d] >= 0) ? owner[d] : 0);
        check($sformatf("model token[%0d]", d), 32'(t[d]), 32'(1 << tok[d]));
        check($sformatf("model expired[%0d]", d), 32'(e[d]), 32'(exp_m[d]));
        check($sformatf("onehot0 gnt[%0d]", d), 32'($onehot0(g[d])), 1);
        if (!reset && prev_g[d] != 4'b0 && g[d] != 4'b0)
          check($sformatf("no gapless switch[%0d]", d), 32'(g[d]), 32'(prev_g[d]));
        prev_g[d] = reset ? 4'b0 : g[d];
      end
    end
  end

  initial begin
    int order[5];
    prev_g[0] = 4'b0; prev_g[1] = 4'b0;
    reset = 1'b1; req = 4'b0; req2 = 4'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    repeat (5) begin
      @(negedge clk);
      check("s1 gnt", 32'(gnt), 32'h0);
      check("s1 gnt_valid", 32'(gnt_valid), 32'h0);
      check("s1 token", 32'(token), 32'h8);
    end

    // 4: single requester on the MAX_HOLD=2 instance
    req2 = 4'b0010;
    repeat (3) begin
      @(negedge clk); check("s4 gnt a", 32'(gnt2), 32'h2);
      @(negedge clk); check("s4 gnt b", 32'(gnt2), 32'h2);
      @(negedge clk); check("s4 gap", 32'(gnt2), 32'h0);
      check("s4 expired", 32'(expired2), 32'h1);
    end
    req2 = 4'b0000;

    // 2: all requesting, quota expiry rotates grants
    order = '{3, 0, 1, 2, 3};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      repeat (8) begin
        @(negedge clk);
        check("s2 gnt", 32'(gnt), 32'(1 << order[k]));
        check("s2 gnt_id", 32'(gnt_id), 32'(order[k]));
      end
      @(negedge clk);
      check("s2 gap", 32'(gnt), 32'h0);
      check("s2 expired", 32'(expired), 32'h1);
      check("s2 token", 32'(token), 32'(1 << ((order[k] + 1) % 4)));
    end
    req = 4'b0000;
    @(negedge clk);

    // 3: short request, normal release
    req = 4'b0100;
    repeat (3) begin
      @(negedge clk);
      check("s3 gnt", 32'(gnt), 32'h4);
    end
    req = 4'b0000;
    @(negedge clk);
    check("s3 gnt off", 32'(gnt), 32'h0);
    check("s3 expired", 32'(expired), 32'h0);
    check("s3 token", 32'(token), 32'h8);

    // 5: reset during cycle 4 of a grant
    req = 4'b0100;
    repeat (4) begin
      @(negedge clk);
      check("s5 gnt", 32'(gnt), 32'h4);
    end
    reset = 1'b1;
    @(negedge clk);
    check("s5 gnt after reset", 32'(gnt), 32'h0);
    check("s5 token after reset", 32'(token), 32'h8);
    reset = 1'b0;
    @(negedge clk);
    check("s5 regrant", 32'(gnt), 32'h4);
    req = 4'b0000;
    @(negedge clk);

    // 6: request drops on the quota edge
    req = 4'b0001;
    repeat (8) begin
      @(negedge clk);
      check("s6 gnt", 32'(gnt), 32'h1);
    end
    req = 4'b0000;
    @(negedge clk);
    check("s6 gnt off", 32'(gnt), 32'h0);
    check("s6 expired", 32'(expired), 32'h0);
    check("s6 token", 32'(token), 32'h2);

    // Randomized traffic with sticky requests and rare resets
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) req2 = 4'($urandom);
      reset = ($urandom_range(0, 199) == 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
